// File: rtl/booth_pkg.sv
// Shared definitions for the booth multiplier job controller.
// Provides the default operand width, the controller FSM state encoding
// and a helper that returns the product width for a given operand width.
package booth_pkg;

    localparam int N_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    function automatic int prod_w(input int n);
        return 2 * n;
    endfunction

endpackage

// File: rtl/booth_op_fifo.sv
// Synchronous operand FIFO carrying {mplier, mcand} pairs.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   push, push_mplier/mcand  write request and data (ignored while full)
//   pop                      read request (ignored while empty)
//   head_mplier/mcand        entry at the read pointer
//   full, empty, count       occupancy status
import booth_pkg::*;

module booth_op_fifo #(
    parameter int N     = N_DEF,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [N-1:0]             push_mplier,
    input  logic [N-1:0]             push_mcand,
    input  logic                     pop,
    output logic [N-1:0]             head_mplier,
    output logic [N-1:0]             head_mcand,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [2*N-1:0] mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == (AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    // A push while full is dropped even if a pop frees a slot this cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= {push_mplier, push_mcand};
    end

    assign {head_mplier, head_mcand} = mem[rd_ptr];

endmodule

// File: rtl/booth_job_ctrl.sv
// Issue/collect controller for the radix-8 booth multiplier.
// Buffers operand pairs, runs one multiplier job at a time with stable
// operands, captures the product and offers {mplier, mcand, product} on a
// valid/ready port. A watchdog aborts a job whose Done never arrives.
// Ports:
//   Clock, Reset                       clock, asynchronous active-high reset
//   In_Valid/In_Ready/In_Mplier/Mcand  operand input handshake
//   Mul_Start/Mul_Mplier/Mul_Mcand     request to the multiplier
//   Mul_Done/Mul_Product               response from the multiplier
//   Res_Valid/Res_Ready/Res_*          result output handshake
//   Busy                               any job queued, running or unread
//   Error                              sticky watchdog abort flag
import booth_pkg::*;

module booth_job_ctrl #(
    parameter int  N       = N_DEF,
    parameter int  DEPTH   = 4,
    parameter int  TIMEOUT = 64,
    localparam int PW      = prod_w(N)
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          In_Valid,
    output logic          In_Ready,
    input  logic [N-1:0]  In_Mplier,
    input  logic [N-1:0]  In_Mcand,
    output logic          Mul_Start,
    output logic [N-1:0]  Mul_Mplier,
    output logic [N-1:0]  Mul_Mcand,
    input  logic          Mul_Done,
    input  logic [PW-1:0] Mul_Product,
    output logic          Res_Valid,
    input  logic          Res_Ready,
    output logic [N-1:0]  Res_Mplier,
    output logic [N-1:0]  Res_Mcand,
    output logic [PW-1:0] Res_Product,
    output logic          Busy,
    output logic          Error
);

    localparam int WW = $clog2(TIMEOUT + 1);
    localparam int CW = $clog2(DEPTH) + 1;

    state_t         state;
    state_t         state_nx;
    logic           fifo_full;
    logic           fifo_empty;
    logic           fifo_pop;
    logic [CW-1:0]  fifo_count;
    logic [N-1:0]   head_mplier;
    logic [N-1:0]   head_mcand;
    logic [WW-1:0]  wd;
    logic           capture;
    logic           abort;
    logic           wd_inc;

    booth_op_fifo #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (Clock),
        .rst         (Reset),
        .push        (In_Valid),
        .push_mplier (In_Mplier),
        .push_mcand  (In_Mcand),
        .pop         (fifo_pop),
        .head_mplier (head_mplier),
        .head_mcand  (head_mcand),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .count       (fifo_count)
    );

    // Res_Valid is exactly the OUT state, so IDLE never issues over an
    // unread result.
    always_comb begin
        state_nx = state;
        fifo_pop = 1'b0;
        capture  = 1'b0;
        abort    = 1'b0;
        wd_inc   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_nx = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (Mul_Done) begin
                    capture  = 1'b1;
                    state_nx = ST_DRAIN;
                end else if (wd == WW'(TIMEOUT - 1)) begin
                    abort    = 1'b1;
                    state_nx = ST_IDLE;
                end else begin
                    wd_inc = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (!Mul_Done) state_nx = ST_OUT;
            end
            ST_OUT: begin
                if (Res_Ready) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state       <= ST_IDLE;
            wd          <= '0;
            Error       <= 1'b0;
            Mul_Mplier  <= '0;
            Mul_Mcand   <= '0;
            Res_Mplier  <= '0;
            Res_Mcand   <= '0;
            Res_Product <= '0;
        end else begin
            state <= state_nx;
            if (fifo_pop) begin
                Mul_Mplier <= head_mplier;
                Mul_Mcand  <= head_mcand;
                wd         <= '0;
            end else if (wd_inc) begin
                wd <= wd + 1'b1;
            end
            if (abort) Error <= 1'b1;
            if (capture) begin
                Res_Mplier  <= Mul_Mplier;
                Res_Mcand   <= Mul_Mcand;
                Res_Product <= Mul_Product;
            end
        end
    end

    assign In_Ready  = !fifo_full;
    assign Mul_Start = (state == ST_ISSUE);
    assign Res_Valid = (state == ST_OUT);
    assign Busy      = (state != ST_IDLE) || (fifo_count != '0) || Res_Valid;

endmodule
